// File: rtl/rgb_quad_gather.sv
// ---------------------------------------------------------------------------
// rgb_quad_gather
//   Gathers a raster-order RGB pixel stream into 2x2 quads for the 4:2:0
//   converter. Each even row is held in a line buffer. On the following odd
//   row, every even-column pixel is latched into a left register. Every
//   odd-column pixel then completes a quad.
//
// Ports
//   clk, rst        clock (posedge) / asynchronous active-high reset
//   in_valid        in_pixel/in_sof valid
//   in_ready        pixel accepted this cycle when in_valid is high
//   in_pixel        {b, g, r} pixel
//   in_sof          pixel is row 0, col 0 of a frame
//   out_valid       quad held on out_* ports
//   out_ready       converter consumes the quad this cycle
//   out_up_left     pixel (2r,   2c)
//   out_up_right    pixel (2r,   2c+1)
//   out_down_left   pixel (2r+1, 2c)
//   out_down_right  pixel (2r+1, 2c+1)
//   out_eof         quad is the last of the frame
//   sof_err         one-cycle pulse: in_sof accepted away from frame start
// ---------------------------------------------------------------------------
module rgb_quad_gather #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_pixel,
    input  logic        in_sof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_up_left,
    output logic [23:0] out_up_right,
    output logic [23:0] out_down_left,
    output logic [23:0] out_down_right,
    output logic        out_eof,
    output logic        sof_err
);

    localparam int CW = (LINE_WIDTH   > 1) ? $clog2(LINE_WIDTH)   : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TOP,
        ST_BOTTOM
    } state_t;

    state_t        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [23:0]   left_q;
    logic          out_valid_q;
    logic [23:0]   up_left_q;
    logic [23:0]   up_right_q;
    logic [23:0]   down_left_q;
    logic [23:0]   down_right_q;
    logic          eof_q;
    logic          sof_err_q;

    // Line buffer holds the most recent even row; not reset.
    logic [23:0]   line_buf [LINE_WIDTH];

    logic          accept;
    logic          start;
    logic          restart;
    logic          col_last;
    logic          row_last;
    logic [CW-1:0] col_inc_d;
    logic [RW-1:0] row_inc_d;
    logic [CW-1:0] rd_left_addr;
    logic          buf_we;
    logic [CW-1:0] buf_waddr;

    // A slot opens whenever the output register is empty or being drained.
    assign in_ready = !out_valid_q || out_ready;

    always_comb begin
        accept       = in_valid && in_ready;
        start        = accept && in_sof && (state_q == ST_IDLE);
        // An in_sof inside a frame is only legal at the origin; anywhere else
        // it abandons the partial frame and restarts with this pixel.
        restart      = accept && in_sof && (state_q != ST_IDLE) &&
                       !((col_q == '0) && (row_q == '0));
        col_last     = (col_q == COL_LAST);
        row_last     = (row_q == ROW_LAST);
        col_inc_d    = col_q + 1'b1;
        row_inc_d    = row_q + 1'b1;
        // Only used on odd columns, so col-1 is the even partner column.
        rd_left_addr = col_q - 1'b1;
        buf_we       = start || restart || (accept && (state_q == ST_TOP));
        buf_waddr    = (start || restart) ? '0 : col_q;
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            line_buf[buf_waddr] <= in_pixel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            left_q       <= '0;
            out_valid_q  <= 1'b0;
            up_left_q    <= '0;
            up_right_q   <= '0;
            down_left_q  <= '0;
            down_right_q <= '0;
            eof_q        <= 1'b0;
            sof_err_q    <= 1'b0;
        end else begin
            sof_err_q <= 1'b0;

            // Drain first; a quad loaded below in the same cycle overrides
            // this, giving back-to-back delivery.
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                if (start || restart) begin
                    // The sof pixel itself is stored as col 0 of row 0.
                    col_q     <= CW'(1);
                    row_q     <= '0;
                    state_q   <= ST_TOP;
                    sof_err_q <= restart;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            // Pixels outside a frame are dropped.
                        end
                        ST_TOP: begin
                            if (col_last) begin
                                col_q   <= '0;
                                row_q   <= row_inc_d;
                                state_q <= ST_BOTTOM;
                            end else begin
                                col_q <= col_inc_d;
                            end
                        end
                        ST_BOTTOM: begin
                            if (!col_q[0]) begin
                                left_q <= in_pixel;
                            end else begin
                                up_left_q    <= line_buf[rd_left_addr];
                                up_right_q   <= line_buf[col_q];
                                down_left_q  <= left_q;
                                down_right_q <= in_pixel;
                                eof_q        <= col_last && row_last;
                                out_valid_q  <= 1'b1;
                            end
                            if (col_last) begin
                                col_q <= '0;
                                if (row_last) begin
                                    row_q   <= '0;
                                    state_q <= ST_IDLE;
                                end else begin
                                    row_q   <= row_inc_d;
                                    state_q <= ST_TOP;
                                end
                            end else begin
                                col_q <= col_inc_d;
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_up_left    = up_left_q;
    assign out_up_right   = up_right_q;
    assign out_down_left  = down_left_q;
    assign out_down_right = down_right_q;
    assign out_eof        = eof_q;
    assign sof_err        = sof_err_q;

endmodule

// File: tb/tb_rgb_quad_gather.sv
// ---------------------------------------------------------------------------
// tb_rgb_quad_gather
//   Scoreboard bench for rgb_quad_gather with a 4x2 frame. Expected quads are
//   derived from frame geometry when a frame is driven. They are compared in
//   order as the DUT hands them over.
// ---------------------------------------------------------------------------
module tb_rgb_quad_gather;

    localparam int LW = 4;
    localparam int FH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_pixel;
    logic        in_sof;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_up_left;
    logic [23:0] out_up_right;
    logic [23:0] out_down_left;
    logic [23:0] out_down_right;
    logic        out_eof;
    logic        sof_err;

    rgb_quad_gather #(
        .LINE_WIDTH  (LW),
        .FRAME_HEIGHT(FH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pixel      (in_pixel),
        .in_sof        (in_sof),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_up_left   (out_up_left),
        .out_up_right  (out_up_right),
        .out_down_left (out_down_left),
        .out_down_right(out_down_right),
        .out_eof       (out_eof),
        .sof_err       (sof_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Quad packing: {eof, up_left, up_right, down_left, down_right}
    logic [96:0] sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          sof_err_cnt = 0;
    int          quads_seen  = 0;
    logic        ready_mon   = 1'b0;
    logic        ready_drop  = 1'b0;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix(input logic [23:0] base, input int r,
                                        input int c);
        return base + 24'(r * LW + c + 1);
    endfunction

    function automatic logic [96:0] quad(input logic [23:0] base, input int qr,
                                         input int qc);
        logic eof;
        eof = (qr == FH/2 - 1) && (qc == LW/2 - 1);
        return {eof, pix(base, 2*qr, 2*qc), pix(base, 2*qr, 2*qc+1),
                pix(base, 2*qr+1, 2*qc), pix(base, 2*qr+1, 2*qc+1)};
    endfunction

    // Scoreboard consumer: one compare per transfer.
    always @(negedge clk) begin
        logic [96:0] exp_q;
        if (!rst && out_valid && out_ready) begin
            exp_q = (sb.size() != 0) ? sb.pop_front() : '0;
            quads_seen++;
            check_val("quad", {out_eof, out_up_left, out_up_right,
                               out_down_left, out_down_right}, exp_q);
        end
        if (sof_err) sof_err_cnt++;
        if (ready_mon && in_valid && !in_ready) ready_drop = 1'b1;
    end

    // Called at posedge+1; returns at posedge+1 after the pixel is accepted.
    task automatic send_pixel(input logic [23:0] p, input logic sof);
        int t = 0;
        in_valid = 1'b1;
        in_pixel = p;
        in_sof   = sof;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check_val("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_sof = 1'b0;
    endtask

    task automatic drive_frame(input logic [23:0] base);
        for (int qr = 0; qr < FH/2; qr++)
            for (int qc = 0; qc < LW/2; qc++)
                sb.push_back(quad(base, qr, qc));
        for (int i = 0; i < LW*FH; i++)
            send_pixel(pix(base, i / LW, i % LW), (i == 0));
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_val(tag, sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pixel  = '0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_in_ready",  in_ready, 1);
        check_val("rst_quad", {out_eof, out_up_left, out_up_right,
                               out_down_left, out_down_right}, 0);
        check_val("rst_sof_err", sof_err, 0);
        @(posedge clk);
        #1;

        // 1: single frame, always ready -> {1,2,5,6} then {3,4,7,8} eof
        quads_seen = 0;
        drive_frame(24'h000000);
        in_valid = 1'b0;
        drain("t1_drain");
        check_val("t1_quads", quads_seen, 2);

        // 2: backpressure for 5 cycles after the first quad
        out_ready = 1'b0;
        fork
            drive_frame(24'h000000);
            begin : hold
                int t = 0;
                while (!out_valid && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check_val("t2_hold_seen", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    check_val("t2_hold_quad", {out_eof, out_up_left,
                              out_up_right, out_down_left, out_down_right},
                              {1'b0, 24'h1, 24'h2, 24'h5, 24'h6});
                    check_val("t2_hold_in_ready", in_ready, 0);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain("t2_drain");

        // 3: two frames back to back with in_valid held high
        quads_seen = 0;
        ready_drop = 1'b0;
        ready_mon  = 1'b1;
        drive_frame(24'h100000);
        drive_frame(24'h200000);
        ready_mon  = 1'b0;
        in_valid   = 1'b0;
        drain("t3_drain");
        check_val("t3_quads", quads_seen, 4);
        check_val("t3_in_ready_held", ready_drop, 0);

        // 4: stray pixels in IDLE are dropped
        for (int i = 0; i < 3; i++) send_pixel(24'hAA0000 + 24'(i), 1'b0);
        drive_frame(24'h300000);
        in_valid = 1'b0;
        drain("t4_drain");
        check_val("t4_no_sof_err", sof_err_cnt, 0);

        // 5: sof at row 1 col 2 restarts the frame
        sof_err_cnt = 0;
        sb.push_back({1'b0, 24'h1, 24'h2, 24'h5, 24'h6});
        for (int i = 0; i < 6; i++)
            send_pixel(pix(24'h0, i / LW, i % LW), (i == 0));
        check_val("t5_pre_sof_err", sof_err_cnt, 0);
        drive_frame(24'h000010);
        in_valid = 1'b0;
        drain("t5_drain");
        check_val("t5_sof_err_pulses", sof_err_cnt, 1);

        // 6: async reset mid row 1 with a quad pending
        out_ready = 1'b0;
        sb.push_back({1'b0, 24'h1, 24'h2, 24'h5, 24'h6});
        for (int i = 0; i < 6; i++)
            send_pixel(pix(24'h0, i / LW, i % LW), (i == 0));
        in_valid = 1'b0;
        @(negedge clk);
        check_val("t6_pending", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check_val("t6_rst_out_valid", out_valid, 0);
        check_val("t6_rst_in_ready", in_ready, 1);
        check_val("t6_rst_up_left", out_up_left, 0);
        sb.delete();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        quads_seen = 0;
        drive_frame(24'h400000);
        in_valid = 1'b0;
        drain("t6_drain");
        check_val("t6_quads", quads_seen, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
